// File: rtl/add_arb_pkg.sv
// Shared definitions for the adder-sharing arbiter: datapath width,
// output-buffer state encoding and default parameter values.
package add_arb_pkg;

  localparam int ADD_W    = 32;
  localparam int NREQ_DEF = 4;
  localparam int CNTW_DEF = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/adder32.sv
// Plain 32-bit adder with carry in/out, shared between all requesters.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {32'd0, ci};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic found;
  int   idx;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_id   = IDW'(idx);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one adder32 between NREQ requesters, with a
// single-entry result register. Define ADD_ARB_STATS_EN for grant counters.
module add_share_arb
  import add_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
`ifdef ADD_ARB_STATS_EN
  parameter  int CNTW = CNTW_DEF,
`endif
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*ADD_W-1:0] req_a,
  input  logic [NREQ*ADD_W-1:0] req_b,
  input  logic [NREQ-1:0]       req_ci,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ADD_W-1:0]      resp_sum,
  output logic                  resp_co,
  output logic [IDW-1:0]        resp_id
`ifdef ADD_ARB_STATS_EN
  ,
  output logic [NREQ*CNTW-1:0]  grant_cnt
`endif
);

  state_t           state, state_next;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_id;
  logic [NREQ-1:0]  gnt;
  logic             arb_en;
  logic             granted;
  logic [ADD_W-1:0] add_a, add_b, add_s;
  logic             add_ci, add_co;

  // NOTE: reset gates the arbiter enable so no request is accepted while rst is held,
  // even though the EMPTY state alone would otherwise allow a grant.
  assign arb_en     = ((state == EMPTY) || resp_ready) && !rst;
  assign granted    = |gnt;
  assign req_ready  = gnt;
  assign resp_valid = (state == FULL);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Idle adder inputs are forced to zero so the adder does not toggle.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (granted) begin
      add_a  = req_a[int'(gnt_id)*ADD_W +: ADD_W];
      add_b  = req_b[int'(gnt_id)*ADD_W +: ADD_W];
      add_ci = req_ci[gnt_id];
    end
  end

  adder32 u_add (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY: if (granted) state_next = FULL;
      FULL:  if (resp_ready && !granted) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= '0;
      resp_sum <= '0;
      resp_co  <= 1'b0;
      resp_id  <= '0;
    end else begin
      state <= state_next;
      if (granted) begin
        resp_sum <= add_s;
        resp_co  <= add_co;
        resp_id  <= gnt_id;
        ptr      <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

`ifdef ADD_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    logic [CNTW-1:0] cnt;

    // Saturating: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                      cnt <= '0;
      else if (gnt[i] && cnt != '1) cnt <= cnt + 1'b1;
    end

    assign grant_cnt[i*CNTW +: CNTW] = cnt;
  end
`endif

endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model of the arbiter.
module tb_add_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int IDW  = 2;
`ifdef ADD_ARB_STATS_EN
  localparam int CNTW = 2;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*W-1:0]   req_a = '0;
  logic [NREQ*W-1:0]   req_b = '0;
  logic [NREQ-1:0]     req_ci = '0;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic                resp_ready = 1'b1;
  logic [W-1:0]        resp_sum;
  logic                resp_co;
  logic [IDW-1:0]      resp_id;
`ifdef ADD_ARB_STATS_EN
  logic [NREQ*CNTW-1:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: result buffer contents and rotation pointer.
  logic        m_full = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic        m_co   = 1'b0;
  int          m_id   = 0;
  int          m_ptr  = 0;
  int          last_g = -1;

  always #5 clk = ~clk;

`ifdef ADD_ARB_STATS_EN
  add_share_arb #(.NREQ(NREQ), .CNTW(CNTW)) dut (
`else
  add_share_arb #(.NREQ(NREQ)) dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ci     (req_ci),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_co    (resp_co),
    .resp_id    (resp_id)
`ifdef ADD_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Which requester the rules say must be accepted this cycle, or -1.
  function automatic int exp_grant();
    if (rst || (m_full && !resp_ready)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_tick();
    int g;
    logic [W:0] full;
    g = exp_grant();
    last_g = g;
    if (g >= 0) begin
      full = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]} + {32'd0, req_ci[g]};
      m_sum  = full[W-1:0];
      m_co   = full[W];
      m_id   = g;
      m_full = 1'b1;
      m_ptr  = (g + 1) % NREQ;
    end else if (m_full && resp_ready && !rst) begin
      m_full = 1'b0;
    end
  endtask

  // One clock: update the model at the edge, then retire the granted request.
  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    if (last_g >= 0) req_valid[last_g] = 1'b0;
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (v) begin
      m_full = 1'b0;
      m_ptr  = 0;
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_ci[i]       = ci;
    req_valid[i]    = 1'b1;
  endtask

  task automatic pulse_rst();
    set_rst(1'b1);
    step();
    step();
    set_rst(1'b0);
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int eg;
    logic [NREQ-1:0] er;
    eg = exp_grant();
    er = '0;
    if (eg >= 0) er[eg] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(er));
    check("resp_valid", 64'(resp_valid), 64'(m_full));
    if (m_full) begin
      check("resp_sum", 64'(resp_sum), 64'(m_sum));
      check("resp_co", 64'(resp_co), 64'(m_co));
      check("resp_id", 64'(resp_id), 64'(m_id));
    end
  end

  initial begin
    // Reset values
    set_rst(1'b1);
    step();
    step();
    set_rst(1'b0);
    #1;
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_sum", 64'(resp_sum), 64'd0);
    check("rst_co", 64'(resp_co), 64'd0);
    check("rst_id", 64'(resp_id), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);

    // Single requester
    resp_ready = 1'b1;
    set_req(0, 32'd5, 32'd10, 1'b1);
    step();
    #1;
    check("single_valid", 64'(resp_valid), 64'd1);
    check("single_sum", 64'(resp_sum), 64'd16);
    check("single_co", 64'(resp_co), 64'd0);
    check("single_id", 64'(resp_id), 64'd0);

    // Round-robin with everyone valid
    step();
    pulse_rst();
    set_req(0, 32'd37, 32'd48, 1'b0);
    set_req(1, 32'd125, 32'd110, 1'b1);
    set_req(2, 32'd63, 32'd211, 1'b0);
    set_req(3, 32'd122, 32'd11, 1'b1);
    begin
      logic [W-1:0] rr_sum [NREQ];
      rr_sum[0] = 32'd85; rr_sum[1] = 32'd236; rr_sum[2] = 32'd274; rr_sum[3] = 32'd134;
      for (int i = 0; i < NREQ; i++) begin
        step();
        #1;
        check("rr_sum", 64'(resp_sum), 64'(rr_sum[i]));
        check("rr_id", 64'(resp_id), 64'(i));
      end
    end
    step();

    // Backpressure
    set_req(0, 32'd245, 32'd2, 1'b0);
    step();
    resp_ready = 1'b0;
    set_req(1, 32'd7, 32'd8, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_sum", 64'(resp_sum), 64'd247);
      check("bp_ready", 64'(req_ready), 64'd0);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check("bp_drain_grant", 64'(req_ready), 64'b0010);
    step();
    #1;
    check("bp_next_sum", 64'(resp_sum), 64'd15);
    check("bp_next_id", 64'(resp_id), 64'd1);

    // Carry-out wrap
    set_req(3, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step();
    #1;
    check("wrap_sum", 64'(resp_sum), 64'd1);
    check("wrap_co", 64'(resp_co), 64'd1);
    set_req(3, 32'd127, 32'd127, 1'b1);
    step();
    #1;
    check("nowrap_sum", 64'(resp_sum), 64'd255);
    check("nowrap_co", 64'(resp_co), 64'd0);

    // Reset while FULL with req 2 pending
    resp_ready = 1'b0;
    set_req(2, 32'd9, 32'd9, 1'b0);
    set_rst(1'b1);
    #1;
    check("midrst_valid", 64'(resp_valid), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    step();
    step();
    set_rst(1'b0);
    resp_ready = 1'b1;
    set_req(0, 32'd1, 32'd2, 1'b0);
    #1;
    check("postrst_first", 64'(req_ready), 64'b0001);
    step();
    #1;
    check("postrst_id0", 64'(resp_id), 64'd0);
    step();
    #1;
    check("postrst_id2", 64'(resp_id), 64'd2);
    step();

`ifdef ADD_ARB_STATS_EN
    pulse_rst();
    for (int n = 0; n < 5; n++) begin
      set_req(1, 32'(n), 32'd1, 1'b0);
      step();
    end
    step();
    for (int i = 0; i < NREQ; i++)
      check("grant_cnt", 64'(grant_cnt[i*CNTW +: CNTW]), (i == 1) ? 64'd3 : 64'd0);
`endif

    // Randomized traffic; requests hold until accepted
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299, 0) == 0) set_rst(1'b1);
      else if (rst) set_rst(1'b0);
      resp_ready = ($urandom_range(3, 0) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          logic [W-1:0] a, b;
          a = $urandom();
          b = $urandom();
          if ($urandom_range(7, 0) == 0) a = 32'hFFFF_FFFF;
          if ($urandom_range(7, 0) == 0) b = 32'hFFFF_FFFF;
          set_req(i, a, b, 1'($urandom_range(1, 0)));
        end
      end
      step();
    end
    set_rst(1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
